// File: rtl/dmem_port_arbiter.sv
// Arbiter for the single-port NN data memory. Capture writes always win.
// SPART and NN share the remaining slots round-robin; all commands are registered.
module dmem_port_arbiter #(
  parameter int AW       = 7,
  parameter int DW       = 256,
  parameter int WAIT_MAX = 64,
  parameter int CNT_W    = 8
) (
  input  logic             pxlclk,
  input  logic             rst_n,
  input  logic             cap_wren,
  input  logic [AW-1:0]    cap_addr,
  input  logic [DW-1:0]    cap_wdata,
  input  logic             spt_req,
  input  logic             spt_we,
  input  logic [AW-1:0]    spt_addr,
  input  logic [DW-1:0]    spt_wdata,
  output logic             spt_gnt,
  output logic             spt_rvalid,
  input  logic             nn_req,
  input  logic             nn_we,
  input  logic [AW-1:0]    nn_addr,
  input  logic [DW-1:0]    nn_wdata,
  output logic             nn_gnt,
  output logic             nn_rvalid,
  output logic [DW-1:0]    rdata,
  output logic             mem_wren,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic [CNT_W-1:0] coll_cnt,
  output logic             spt_tmo,
  output logic             nn_tmo
);

  localparam int WCW = $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(WAIT_MAX);
  localparam logic [CNT_W-1:0] COLL_SAT = {CNT_W{1'b1}};

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_CAP  = 2'd1;
  localparam logic [1:0] SRC_SPT  = 2'd2;
  localparam logic [1:0] SRC_NN   = 2'd3;

  logic             spt_elig_s, nn_elig_s, coll_s;
  logic [1:0]       src_s;

  logic             mem_wren_q, mem_wren_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic             spt_gnt_q, spt_gnt_d, nn_gnt_q, nn_gnt_d;
  logic             spt_rd_q, spt_rd_d, nn_rd_q, nn_rd_d;
  logic             spt_rvalid_q, nn_rvalid_q;
  logic [DW-1:0]    rdata_q;
  logic             rr_nn_last_q, rr_nn_last_d;
  logic [CNT_W-1:0] coll_q, coll_d;
  logic [WCW-1:0]   spt_wait_q, spt_wait_d, nn_wait_q, nn_wait_d;
  logic             spt_tmo_q, spt_tmo_d, nn_tmo_q, nn_tmo_d;

  // A pending request only ages while it is eligible and losing; req dropping or a win resets it.
  function automatic logic [WCW-1:0] wait_next(input logic req, input logic elig,
                                               input logic won, input logic [WCW-1:0] cnt);
    if (!req || won) begin
      return {WCW{1'b0}};
    end else if (elig && (cnt != WAIT_SAT)) begin
      return cnt + WCW'(1);
    end else begin
      return cnt;
    end
  endfunction

  // Pick this cycle's winner; a master is masked in the cycle its grant is shown.
  always_comb begin
    spt_elig_s = spt_req & ~spt_gnt_q;
    nn_elig_s  = nn_req & ~nn_gnt_q;
    coll_s     = cap_wren & (spt_elig_s | nn_elig_s);
    if (cap_wren) begin
      src_s = SRC_CAP;
    end else if (spt_elig_s && nn_elig_s) begin
      src_s = rr_nn_last_q ? SRC_SPT : SRC_NN;
    end else if (spt_elig_s) begin
      src_s = SRC_SPT;
    end else if (nn_elig_s) begin
      src_s = SRC_NN;
    end else begin
      src_s = SRC_NONE;
    end
  end

  // Next memory command, grant pulses and round-robin pointer.
  always_comb begin
    mem_wren_d   = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    spt_gnt_d    = 1'b0;
    nn_gnt_d     = 1'b0;
    spt_rd_d     = 1'b0;
    nn_rd_d      = 1'b0;
    rr_nn_last_d = rr_nn_last_q;
    case (src_s)
      SRC_CAP: begin
        mem_wren_d  = 1'b1;
        mem_addr_d  = cap_addr;
        mem_wdata_d = cap_wdata;
      end
      SRC_SPT: begin
        mem_wren_d   = spt_we;
        mem_addr_d   = spt_addr;
        mem_wdata_d  = spt_wdata;
        spt_gnt_d    = 1'b1;
        spt_rd_d     = ~spt_we;
        rr_nn_last_d = 1'b0;
      end
      SRC_NN: begin
        mem_wren_d   = nn_we;
        mem_addr_d   = nn_addr;
        mem_wdata_d  = nn_wdata;
        nn_gnt_d     = 1'b1;
        nn_rd_d      = ~nn_we;
        rr_nn_last_d = 1'b1;
      end
      default: begin
        mem_wren_d = 1'b0;
      end
    endcase
  end

  // Collision counter, wait counters and sticky timeout flags.
  always_comb begin
    if (coll_s && (coll_q != COLL_SAT)) begin
      coll_d = coll_q + CNT_W'(1);
    end else begin
      coll_d = coll_q;
    end
    spt_wait_d = wait_next(spt_req, spt_elig_s, src_s == SRC_SPT, spt_wait_q);
    nn_wait_d  = wait_next(nn_req, nn_elig_s, src_s == SRC_NN, nn_wait_q);
    spt_tmo_d  = spt_tmo_q | (spt_wait_d == WAIT_SAT);
    nn_tmo_d   = nn_tmo_q | (nn_wait_d == WAIT_SAT);
  end

  // State registers; reset also discards any read still in flight.
  always_ff @(posedge pxlclk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wren_q   <= 1'b0;
      mem_addr_q   <= {AW{1'b0}};
      mem_wdata_q  <= {DW{1'b0}};
      spt_gnt_q    <= 1'b0;
      nn_gnt_q     <= 1'b0;
      spt_rd_q     <= 1'b0;
      nn_rd_q      <= 1'b0;
      spt_rvalid_q <= 1'b0;
      nn_rvalid_q  <= 1'b0;
      rdata_q      <= {DW{1'b0}};
      rr_nn_last_q <= 1'b1;
      coll_q       <= {CNT_W{1'b0}};
      spt_wait_q   <= {WCW{1'b0}};
      nn_wait_q    <= {WCW{1'b0}};
      spt_tmo_q    <= 1'b0;
      nn_tmo_q     <= 1'b0;
    end else begin
      mem_wren_q   <= mem_wren_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      spt_gnt_q    <= spt_gnt_d;
      nn_gnt_q     <= nn_gnt_d;
      spt_rd_q     <= spt_rd_d;
      nn_rd_q      <= nn_rd_d;
      spt_rvalid_q <= spt_rd_q;
      nn_rvalid_q  <= nn_rd_q;
      rdata_q      <= rdata;
      rr_nn_last_q <= rr_nn_last_d;
      coll_q       <= coll_d;
      spt_wait_q   <= spt_wait_d;
      nn_wait_q    <= nn_wait_d;
      spt_tmo_q    <= spt_tmo_d;
      nn_tmo_q     <= nn_tmo_d;
    end
  end

  // The RAM output is only valid in the return cycle, so it is passed straight through then.
  assign rdata      = (spt_rvalid_q | nn_rvalid_q) ? mem_rdata : rdata_q;
  assign spt_gnt    = spt_gnt_q;
  assign nn_gnt     = nn_gnt_q;
  assign spt_rvalid = spt_rvalid_q;
  assign nn_rvalid  = nn_rvalid_q;
  assign mem_wren   = mem_wren_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign coll_cnt   = coll_q;
  assign spt_tmo    = spt_tmo_q;
  assign nn_tmo     = nn_tmo_q;

endmodule
